imem_boot_ctrl: RTL and testbench
=================================

IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter FETCH_LIMIT, default 128, number of word slots fetchable and loadable.
REQ-003 SHALL have parameter HALT_INSTR, default 32'h00000063, the halt encoding (beq x0,x0,0).
REQ-004 SHALL have parameter TERM_WORD, default 32'hFFFFFFFF, the load terminator word.
REQ-005 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- load_start  in  1  begin image load (pulse).
- go_run  in  1  run the existing image without loading (pulse).
- rx_valid  in  1  rx_data byte valid this cycle.
- rx_data  in  8  boot byte stream, little-endian within a word.
- cpu_addr  in  32  CPU fetch address (PC).
- cpu_instr  out  32  instruction returned to the CPU.
- cpu_hold  out  1  holds the CPU stalled while high.
- mem_raddr  out  8  memory read word index.
- mem_rdata  in  32  memory read data, asynchronous read.
- mem_we  out  1  memory write strobe.
- mem_waddr  out  8  memory write word index.
- mem_wdata  out  32  memory write data.
- load_done  out  1  high for one cycle when a load completes.
- word_count  out  9  number of words written by the last load.
- halted  out  1  high while in state HALT.

Function
REQ-006 SHALL implement a four-state FSM with states IDLE, LOAD, RUN and HALT.
REQ-007 In IDLE: load_start SHALL move the FSM to LOAD; otherwise go_run SHALL move it to RUN; if both are high in the same cycle, load_start SHALL win.
REQ-008 On entry to LOAD, the byte index, word pointer and word_count SHALL be cleared to 0.
REQ-009 In LOAD, each rx_valid byte SHALL be placed into bits [8k+7:8k] of the assembly register, where k is the byte index (0..3).
REQ-010 When the 4th byte arrives and the assembled word is not TERM_WORD, the block SHALL, in the following cycle, drive mem_we=1 for exactly one cycle, with mem_waddr equal to the word pointer and mem_wdata equal to the assembled word. The word pointer and word_count SHALL then increment.
REQ-011 A completed word equal to TERM_WORD SHALL NOT be written, and SHALL end the load.
REQ-012 The load SHALL also end after the write of word FETCH_LIMIT-1; any rx bytes after that point SHALL be ignored.
REQ-013 When a load ends, the block SHALL pulse load_done for one cycle and move to RUN.
REQ-014 In any state other than LOAD, rx_valid SHALL be ignored and mem_we SHALL be 0.
REQ-015 load_start while in LOAD SHALL have no effect.
REQ-016 In RUN: cpu_hold SHALL be 0, and mem_raddr SHALL equal cpu_addr[9:2].
REQ-017 In RUN: cpu_instr SHALL equal mem_rdata when cpu_addr[11:2] < FETCH_LIMIT, and HALT_INSTR otherwise. This path SHALL be combinational (same-cycle).
REQ-018 In RUN, if cpu_instr equals HALT_INSTR at a clock edge, the FSM SHALL move to HALT.
REQ-019 In HALT: halted SHALL be 1, and load_start SHALL move the FSM to LOAD.
REQ-020 In IDLE, LOAD and HALT: cpu_hold SHALL be 1 and cpu_instr SHALL be HALT_INSTR.
REQ-021 word_count SHALL hold its value until the next entry to LOAD; its range is 0..FETCH_LIMIT.

Reset
REQ-022 On a clock edge with rst=1, the block SHALL set:
- state = IDLE
- cpu_hold = 1, mem_we = 0, load_done = 0, halted = 0
- word_count = 0, byte index = 0, word pointer = 0
REQ-023 A reset during LOAD SHALL discard any partial word and issue no further writes. Words already written SHALL remain in memory.

Structure
REQ-024 The state encoding, HALT_INSTR, TERM_WORD and FETCH_LIMIT SHALL live in a shared package, imem_pkg.
REQ-025 Byte-to-word assembly SHALL be one sub-module, byte_word_asm, with outputs word_valid and word.
REQ-026 The memory array SHALL be outside this block; the block connects only through the mem_* ports.

Verification
REQ-027 Scenario: reset, then load_start, then bytes 13 05 A0 00 and FF FF FF FF.
Required: one write, mem_waddr=0, mem_wdata=32'h00A00513; then load_done pulse; word_count=1; state RUN.
REQ-028 Scenario: 128 words streamed with no terminator.
Required: the last write is at mem_waddr=127; load_done follows; word_count=128; the 129th word's bytes produce no write.
REQ-029 Scenario: RUN with cpu_addr=32'h200 (index 128).
Required: cpu_instr=32'h00000063; at the next edge halted=1 and cpu_hold=1.
REQ-030 Scenario: rst asserted after 2 bytes of a word in LOAD.
Required: next cycle state IDLE, cpu_hold=1, no mem_we; a fresh load then starts writing at address 0.
REQ-031 Scenario: load_start and go_run high in the same IDLE cycle.
Required: state LOAD; rx bytes are accepted.
REQ-032 Scenario: rx_valid toggling while in RUN and HALT.
Required: mem_we stays 0 and word_count is unchanged.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot controller.
// Holds the FSM state encoding, the default halt / terminator encodings,
// the fetch/load window size and the byte-assembly constant.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    // Number of word slots that can be loaded and fetched.
    localparam int          FETCH_LIMIT = 128;
    // beq x0,x0,0 : the CPU spins on itself, used as the halt marker.
    localparam logic [31:0] HALT_INSTR  = 32'h0000_0063;
    // A complete word with this value ends a load and is not stored.
    localparam logic [31:0] TERM_WORD   = 32'hFFFF_FFFF;
    // Byte index of the final byte in a little-endian 32-bit word.
    localparam logic [1:0]  LAST_BYTE   = 2'd3;

endpackage

// File: rtl/byte_word_asm.sv
// Little-endian byte-to-word assembler.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           synchronous clear of the partial word (start of a load)
//   en            accept bytes only while high
//   byte_valid    byte_data is valid this cycle
//   byte_data     incoming byte; byte k lands in bits [8k+7:8k]
//   word_valid    high in the cycle the 4th byte arrives (combinational)
//   word          assembled word, valid with word_valid
module byte_word_asm
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_q;
    logic [23:0] lo_q;    // bytes 0..2 of the word under assembly
    logic        take;

    assign take       = en && byte_valid;
    // The 4th byte is forwarded directly so the word is usable in the same
    // cycle it completes; only the lower three bytes are ever stored.
    assign word_valid = take && (idx_q == LAST_BYTE);
    assign word       = {byte_data, lo_q};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx_q <= '0;
            lo_q  <= '0;
        end else if (take) begin
            case (idx_q)
                2'd0:    lo_q[7:0]   <= byte_data;
                2'd1:    lo_q[15:8]  <= byte_data;
                2'd2:    lo_q[23:16] <= byte_data;
                default: ;
            endcase
            idx_q <= idx_q + 2'd1;   // wraps to 0 after the 4th byte
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot controller.
// Loads a program image from a byte stream into an external word memory,
// then releases the CPU and serves its fetches until it hits the halt
// encoding (or fetches outside the loadable window).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   load_start, go_run          commands (pulses) from IDLE / HALT
//   rx_valid, rx_data           boot byte stream
//   cpu_addr, cpu_instr         CPU fetch address and returned instruction
//   cpu_hold                    CPU stall, low only in RUN
//   mem_raddr, mem_rdata        external memory read port (async read)
//   mem_we, mem_waddr, mem_wdata external memory write port
//   load_done                   one-cycle pulse at the end of a load
//   word_count                  words written by the last load
//   halted                      high in HALT
module imem_boot_ctrl
    import imem_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter int          FETCH_LIMIT = imem_pkg::FETCH_LIMIT,
    parameter logic [31:0] HALT_INSTR  = imem_pkg::HALT_INSTR,
    parameter logic [31:0] TERM_WORD   = imem_pkg::TERM_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        go_run,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_instr,
    output logic        cpu_hold,
    output logic [7:0]  mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [7:0]  mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        load_done,
    output logic [8:0]  word_count,
    output logic        halted
);

    localparam logic [10:0] LIMIT_W  = 11'(FETCH_LIMIT);
    localparam logic [10:0] DEPTH_W  = 11'(DEPTH);
    localparam logic [8:0]  LAST_IDX = 9'(FETCH_LIMIT - 1);

    state_e      state_q;
    logic [8:0]  cnt_q;       // word pointer and word_count share this counter
    logic        end_q;       // final slot written; finish after its write cycle
    logic        mem_we_q;
    logic [7:0]  waddr_q;
    logic [31:0] wdata_q;
    logic        load_done_q;

    logic        enter_load;
    logic        asm_en;
    logic        word_valid;
    logic [31:0] word;
    logic [9:0]  fetch_idx;
    logic        in_range;
    logic        unused_addr_bits;

    assign enter_load = load_start && (state_q == ST_IDLE || state_q == ST_HALT);
    // Bytes are dropped once the last slot is taken, even while still in LOAD.
    assign asm_en     = (state_q == ST_LOAD) && !end_q;

    byte_word_asm u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (enter_load),
        .en         (asm_en),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Fetches beyond the loadable window read as halt, so a runaway PC
    // stops the CPU instead of executing stale memory.
    assign fetch_idx = cpu_addr[11:2];
    assign in_range  = ({1'b0, fetch_idx} < LIMIT_W) && ({1'b0, fetch_idx} < DEPTH_W);
    assign cpu_instr = (state_q == ST_RUN && in_range) ? mem_rdata : HALT_INSTR;
    assign cpu_hold  = (state_q != ST_RUN);
    assign halted    = (state_q == ST_HALT);
    assign mem_raddr = cpu_addr[9:2];

    assign mem_we     = mem_we_q;
    assign mem_waddr  = waddr_q;
    assign mem_wdata  = wdata_q;
    assign load_done  = load_done_q;
    assign word_count = cnt_q;

    assign unused_addr_bits = ^{cpu_addr[31:12], cpu_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            end_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            load_done_q <= 1'b0;
        end else begin
            mem_we_q    <= 1'b0;
            load_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        state_q <= ST_LOAD;
                        cnt_q   <= '0;
                        end_q   <= 1'b0;
                    end else if (go_run) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_LOAD: begin
                    if (end_q) begin
                        // The final write is on the bus this cycle; leave after it.
                        state_q     <= ST_RUN;
                        load_done_q <= 1'b1;
                        end_q       <= 1'b0;
                    end else if (word_valid) begin
                        if (word == TERM_WORD) begin
                            state_q     <= ST_RUN;
                            load_done_q <= 1'b1;
                        end else begin
                            mem_we_q <= 1'b1;
                            waddr_q  <= cnt_q[7:0];
                            wdata_q  <= word;
                            cnt_q    <= cnt_q + 9'd1;
                            if (cnt_q == LAST_IDX)
                                end_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (cpu_instr == HALT_INSTR)
                        state_q <= ST_HALT;
                end
                ST_HALT: begin
                    if (load_start) begin
                        state_q <= ST_LOAD;
                        cnt_q   <= '0;
                        end_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: an external word memory, a write
// monitor, and a reference model that derives the expected write sequence
// directly from the byte stream.
module tb_imem_boot_ctrl;

    localparam logic [31:0] HALT = 32'h0000_0063;
    localparam logic [31:0] TERM = 32'hFFFF_FFFF;
    localparam int          LIM  = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start, go_run, rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] cpu_addr, cpu_instr;
    logic        cpu_hold;
    logic [7:0]  mem_raddr, mem_waddr;
    logic [31:0] mem_rdata, mem_wdata;
    logic        mem_we, load_done, halted;
    logic [8:0]  word_count;

    imem_boot_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .go_run     (go_run),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .cpu_addr   (cpu_addr),
        .cpu_instr  (cpu_instr),
        .cpu_hold   (cpu_hold),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .load_done  (load_done),
        .word_count (word_count),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    // Background content for never-written memory words (never halt/term).
    function automatic logic [31:0] bg(input logic [7:0] i);
        return {i, 24'hC0_FF13};
    endfunction

    // External memory and write monitor
    logic [31:0] mem [256];
    bit          wr_flag [256];
    logic [39:0] wq[$];
    int          done_hi = 0;

    assign mem_rdata = wr_flag[mem_raddr] ? mem[mem_raddr] : bg(mem_raddr);

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wq.push_back({mem_waddr, mem_wdata});
            mem[mem_waddr]     = mem_wdata;
            wr_flag[mem_waddr] = 1'b1;
        end
        if (load_done === 1'b1) done_hi++;
    end

    // Reference model state
    logic [31:0] ref_mem [256];
    logic [7:0]  stim[$];

    task automatic push_word(input logic [31:0] w);
        stim.push_back(w[7:0]);
        stim.push_back(w[15:8]);
        stim.push_back(w[23:16]);
        stim.push_back(w[31:24]);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == TERM) w = 32'h1234_5678;
        return w;
    endfunction

    task automatic pulse_start(input logic with_go);
        load_start = 1'b1;
        go_run     = with_go;
        @(posedge clk); #1;
        load_start = 1'b0;
        go_run     = 1'b0;
    endtask

    task automatic stream();
        foreach (stim[i]) begin
            repeat ($urandom_range(0, 2)) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(posedge clk); #1;
            end
            rx_valid = 1'b1;
            rx_data  = stim[i];
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
    endtask

    // Expected writes: consecutive 4-byte little-endian groups, stopping at
    // the terminator or once the window is full.
    task automatic finish_load(input string tag, input int base_done);
        logic [31:0] expw[$];
        logic [31:0] w;
        int n;
        for (int i = 0; i + 3 < stim.size(); i += 4) begin
            w = {stim[i+3], stim[i+2], stim[i+1], stim[i]};
            if (w == TERM) break;
            expw.push_back(w);
            if (expw.size() == LIM) break;
        end
        for (int i = 0; i < 20 && done_hi == base_done; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk({tag, "_done_cycles"}, done_hi - base_done, 1);
        chk({tag, "_nwr"}, wq.size(), expw.size());
        n = (wq.size() < expw.size()) ? wq.size() : expw.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), {24'd0, wq[i][39:32]}, i);
            chk($sformatf("%s_data%0d", tag, i), wq[i][31:0], expw[i]);
        end
        foreach (expw[i]) ref_mem[i] = expw[i];
        chk({tag, "_word_count"}, {23'd0, word_count}, expw.size());
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 10 && halted !== 1'b1; i++) @(negedge clk);
        chk({tag, "_halted"}, halted, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, idx, nw;
        logic [31:0] r, wc0;

        rst = 1'b1; load_start = 1'b0; go_run = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00; cpu_addr = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = bg(8'(i));

        // Reset state
        repeat (3) @(posedge clk); #1;
        chk("rst_hold",   cpu_hold,   1'b1);
        chk("rst_we",     mem_we,     1'b0);
        chk("rst_done",   load_done,  1'b0);
        chk("rst_halted", halted,     1'b0);
        chk("rst_wc",     {23'd0, word_count}, 0);
        chk("rst_instr",  cpu_instr,  HALT);
        rst = 1'b0;

        // load_start beats go_run; one word then terminator
        wq.delete(); base = done_hi;
        pulse_start(1'b1);
        chk("both_hold", cpu_hold, 1'b1);
        stim.delete();
        stim = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        stream();
        finish_load("first", base);
        chk("first_run_hold", cpu_hold, 1'b0);
        chk("first_run_halted", halted, 1'b0);

        // RUN fetches with rx noise
        wq.delete();
        for (int k = 0; k < 16; k++) begin
            idx = (k == 0) ? 0 : (k == 1) ? LIM - 1 : $urandom_range(0, LIM - 1);
            r = $urandom;
            cpu_addr = (r & 32'hFFFF_F000) | (idx << 2) | (r & 32'h3);
            rx_valid = 1'($urandom);
            rx_data  = 8'($urandom);
            #1;
            chk($sformatf("run_instr%0d", k), cpu_instr, ref_mem[idx]);
            chk($sformatf("run_raddr%0d", k), {24'd0, mem_raddr}, idx);
            @(posedge clk); #1;
        end
        chk("run_hold", cpu_hold, 1'b0);

        // Fetch just past the window returns halt and stops the CPU
        cpu_addr = 32'h200;
        #1;
        chk("oob_instr", cpu_instr, HALT);
        @(posedge clk); #1;
        chk("oob_halted", halted, 1'b1);
        chk("oob_hold", cpu_hold, 1'b1);
        repeat (10) begin
            rx_valid = 1'($urandom);
            rx_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        @(negedge clk);
        chk("idle_rx_nwr", wq.size(), 0);
        chk("idle_rx_wc", {23'd0, word_count}, 1);

        // Full window plus a 129th word that must be ignored
        wq.delete(); base = done_hi; stim.delete();
        for (int i = 0; i < LIM + 1; i++) push_word(rand_word());
        pulse_start(1'b0);
        stream();
        finish_load("full", base);
        if (wq.size() > 0) chk("full_last_addr", {24'd0, wq[wq.size()-1][39:32]}, LIM - 1);
        wait_halt("full");

        // Reset after two bytes: partial word discarded
        wq.delete();
        pulse_start(1'b0);
        rx_valid = 1'b1; rx_data = 8'hAA; @(posedge clk); #1;
        rx_data = 8'hBB; @(posedge clk); #1;
        rx_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_hold", cpu_hold, 1'b1);
        chk("mid_rst_halted", halted, 1'b0);
        chk("mid_rst_we", mem_we, 1'b0);
        chk("mid_rst_wc", {23'd0, word_count}, 0);
        repeat (2) @(negedge clk);
        chk("mid_rst_nwr", wq.size(), 0);

        // Fresh load after reset starts at address 0
        wq.delete(); base = done_hi; stim.delete();
        push_word(rand_word()); push_word(rand_word()); push_word(TERM);
        pulse_start(1'b0);
        stream();
        finish_load("fresh", base);
        wait_halt("fresh");

        // Random short loads, including empty, with junk after terminator
        for (int it = 0; it < 4; it++) begin
            wq.delete(); base = done_hi; stim.delete();
            nw = (it == 0) ? 0 : $urandom_range(1, 12);
            for (int i = 0; i < nw; i++) push_word(rand_word());
            push_word(TERM);
            repeat ($urandom_range(0, 5)) stim.push_back(8'($urandom));
            wc0 = {23'd0, word_count};
            pulse_start(1'b0);
            chk($sformatf("rl%0d_load_hold", it), cpu_hold, 1'b1);
            stream();
            finish_load($sformatf("rl%0d", it), base);
            wait_halt($sformatf("rl%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
